// File: rtl/hack_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the Hack boot loader.
// The bench drives the master side, and the loader uses the slave side.
interface hack_boot_loader_if #(
   parameter int ADDR_W = 15
);
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic [15:0]       im_d;
   logic [ADDR_W-1:0] im_address;
   logic              im_we;
   logic              cpu_reset;
   logic              busy;
   logic              done;
   logic              error;

   modport master (
      output start, rx_data, rx_valid,
      input  im_d, im_address, im_we, cpu_reset, busy, done, error
   );

   modport slave (
      input  start, rx_data, rx_valid,
      output im_d, im_address, im_we, cpu_reset, busy, done, error
   );
endinterface

// File: rtl/hack_boot_loader.sv
// Boot sequencer: receives a length-prefixed, checksummed byte frame, writes it
// into instruction memory, and holds the CPU in reset until the frame is verified.
module hack_boot_loader #(
   parameter int ADDR_W  = 15,
   parameter int TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              reset,
   hack_boot_loader_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK_HI, CHK_LO, RUN, ERROR
   } state_t;

   localparam int            TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [31:0]   MAX_WORDS = 32'd1 << ADDR_W;
   localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

   state_t            state_reg, state_next;
   logic [15:0]       count_reg, count_next;
   logic [7:0]        hi_reg, hi_next;
   logic [7:0]        chk_hi_reg, chk_hi_next;
   logic [ADDR_W:0]   idx_reg, idx_next;
   logic [15:0]       sum_reg, sum_next;
   logic [TMO_W-1:0]  tmo_reg, tmo_next;
   logic [15:0]       im_d_reg, im_d_next;
   logic [ADDR_W-1:0] im_addr_reg, im_addr_next;
   logic              im_we_reg, im_we_next;

   logic [15:0] len_word;
   logic [15:0] data_word;
   logic        in_load;

   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      hi_next      = hi_reg;
      chk_hi_next  = chk_hi_reg;
      idx_next     = idx_reg;
      sum_next     = sum_reg;
      tmo_next     = tmo_reg;
      im_d_next    = im_d_reg;
      im_addr_next = im_addr_reg;
      im_we_next   = 1'b0;
      len_word     = {count_reg[15:8], bus.rx_data};
      data_word    = {hi_reg, bus.rx_data};
      in_load      = (state_reg inside {LEN_LO, DATA_HI, DATA_LO, CHK_HI, CHK_LO});

      // A start pulse restarts from any state and swallows a coincident byte.
      if (bus.start) begin
         state_next = LEN_HI;
         idx_next   = '0;
         sum_next   = '0;
         tmo_next   = '0;
      end else if (bus.rx_valid) begin
         tmo_next = '0;
         unique case (state_reg)
            LEN_HI: begin
               count_next = {bus.rx_data, count_reg[7:0]};
               state_next = LEN_LO;
            end
            LEN_LO: begin
               count_next = len_word;
               idx_next   = '0;
               sum_next   = '0;
               if (32'(len_word) > MAX_WORDS)
                  state_next = ERROR;
               else if (len_word == 16'd0)
                  state_next = CHK_HI;
               else
                  state_next = DATA_HI;
            end
            DATA_HI: begin
               hi_next    = bus.rx_data;
               state_next = DATA_LO;
            end
            DATA_LO: begin
               im_d_next    = data_word;
               im_addr_next = idx_reg[ADDR_W-1:0];
               im_we_next   = 1'b1;
               sum_next     = sum_reg + data_word;
               idx_next     = idx_reg + IDX_ONE;
               if (32'(idx_reg) == 32'(count_reg) - 32'd1)
                  state_next = CHK_HI;
               else
                  state_next = DATA_HI;
            end
            CHK_HI: begin
               chk_hi_next = bus.rx_data;
               state_next  = CHK_LO;
            end
            CHK_LO: begin
               state_next = ({chk_hi_reg, bus.rx_data} == sum_reg) ? RUN : ERROR;
            end
            default: ;
         endcase
      end else if (TIMEOUT != 0 && in_load) begin
         if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
            state_next = ERROR;
            tmo_next   = '0;
         end else begin
            tmo_next = tmo_reg + TMO_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         count_reg   <= '0;
         hi_reg      <= '0;
         chk_hi_reg  <= '0;
         idx_reg     <= '0;
         sum_reg     <= '0;
         tmo_reg     <= '0;
         im_d_reg    <= '0;
         im_addr_reg <= '0;
         im_we_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         hi_reg      <= hi_next;
         chk_hi_reg  <= chk_hi_next;
         idx_reg     <= idx_next;
         sum_reg     <= sum_next;
         tmo_reg     <= tmo_next;
         im_d_reg    <= im_d_next;
         im_addr_reg <= im_addr_next;
         im_we_reg   <= im_we_next;
      end
   end

   // Status decodes straight from the state register so reset acts without a clock.
   assign bus.im_d       = im_d_reg;
   assign bus.im_address = im_addr_reg;
   assign bus.im_we      = im_we_reg;
   assign bus.cpu_reset  = (state_reg != RUN);
   assign bus.busy       = in_load || (state_reg == LEN_HI);
   assign bus.done       = (state_reg == RUN);
   assign bus.error      = (state_reg == ERROR);
endmodule

// File: tb/tb_hack_boot_loader.sv
// Bench for hack_boot_loader: three instances (default, TIMEOUT=16, ADDR_W=4) share
// the stimulus, and a write scoreboard per instance checks every im_we pulse.
module tb_hack_boot_loader;
   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] rx_data;
   logic       rx_valid;
   int         sel;

   always #5 clk = ~clk;

   hack_boot_loader_if #(.ADDR_W(15)) if0 ();
   hack_boot_loader_if #(.ADDR_W(15)) if1 ();
   hack_boot_loader_if #(.ADDR_W(4))  if2 ();

   assign if0.start    = start && (sel == 0);
   assign if1.start    = start && (sel == 1);
   assign if2.start    = start && (sel == 2);
   assign if0.rx_valid = rx_valid && (sel == 0);
   assign if1.rx_valid = rx_valid && (sel == 1);
   assign if2.rx_valid = rx_valid && (sel == 2);
   assign if0.rx_data  = rx_data;
   assign if1.rx_data  = rx_data;
   assign if2.rx_data  = rx_data;

   hack_boot_loader #(.ADDR_W(15), .TIMEOUT(0))  u_dut0 (.clk(clk), .reset(reset), .bus(if0));
   hack_boot_loader #(.ADDR_W(15), .TIMEOUT(16)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
   hack_boot_loader #(.ADDR_W(4),  .TIMEOUT(0))  u_dut2 (.clk(clk), .reset(reset), .bus(if2));

   typedef struct {
      int          addr;
      logic [15:0] data;
   } wr_t;

   wr_t         exp_q0[$];
   wr_t         exp_q1[$];
   wr_t         exp_q2[$];
   logic [15:0] frame_words[$];
   int          n_checks = 0;
   int          n_errors = 0;

   // Scoreboard: pop one expected write per observed im_we pulse.
   task automatic sb_compare(input int k, input int addr, input logic [15:0] data);
      wr_t e;
      int  depth;
      depth = (k == 0) ? exp_q0.size() : (k == 1) ? exp_q1.size() : exp_q2.size();
      n_checks++;
      $display("write dut%0d addr %0d data %h", k, addr, data);
      if (depth == 0) begin
         n_errors++;
         $display("FAIL wr%0d_unexpected: write addr %0d data %h, required no write", k, addr, data);
      end else begin
         if (k == 0)      e = exp_q0.pop_front();
         else if (k == 1) e = exp_q1.pop_front();
         else             e = exp_q2.pop_front();
         if (addr !== e.addr || data !== e.data) begin
            n_errors++;
            $display("FAIL wr%0d_data: addr %0d data %h, required addr %0d data %h",
                     k, addr, data, e.addr, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (if0.im_we === 1'b1) sb_compare(0, int'(if0.im_address), if0.im_d);
      if (if1.im_we === 1'b1) sb_compare(1, int'(if1.im_address), if1.im_d);
      if (if2.im_we === 1'b1) sb_compare(2, int'(if2.im_address), if2.im_d);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push_exp(input int k, input int a, input logic [15:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      if (k == 0)      exp_q0.push_back(e);
      else if (k == 1) exp_q1.push_back(e);
      else             exp_q2.push_back(e);
   endtask

   task automatic send_frame(input int k, input logic [15:0] len, input logic [15:0] chk);
      logic [15:0] w;
      send_byte(len[15:8]);
      send_byte(len[7:0]);
      for (int i = 0; i < frame_words.size(); i++) begin
         w = frame_words[i];
         send_byte(w[15:8]);
         push_exp(k, i, w);
         send_byte(w[7:0]);
      end
      send_byte(chk[15:8]);
      send_byte(chk[7:0]);
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      sel      = 0;
      tick();
      tick();
      n_checks++;
      if ({if0.cpu_reset, if0.im_we, if0.busy, if0.done, if0.error} !== 5'b10000) begin
         n_errors++;
         $display("FAIL reset_flags: cpu_reset/we/busy/done/error=%b, required 10000",
                  {if0.cpu_reset, if0.im_we, if0.busy, if0.done, if0.error});
      end
      n_checks++;
      if (if0.im_d !== 16'h0000 || if0.im_address !== 15'd0) begin
         n_errors++;
         $display("FAIL reset_bus: im_d=%h im_address=%0d, required 0000 and 0", if0.im_d, if0.im_address);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_load_ok();
      sel = 0;
      frame_words = '{16'h0002, 16'hEC10, 16'h0017, 16'hE306, 16'h0010};
      do_start();
      n_checks++;
      if (if0.busy !== 1'b1 || if0.cpu_reset !== 1'b1) begin
         n_errors++;
         $display("FAIL load_busy: busy=%b cpu_reset=%b, required 1 1", if0.busy, if0.cpu_reset);
      end
      send_frame(0, 16'd5, 16'hCF3F);
      n_checks++;
      if ({if0.done, if0.error, if0.cpu_reset, if0.busy} !== 4'b1000) begin
         n_errors++;
         $display("FAIL load_ok: done/error/cpu_reset/busy=%b, required 1000",
                  {if0.done, if0.error, if0.cpu_reset, if0.busy});
      end
      n_checks++;
      if (exp_q0.size() != 0) begin
         n_errors++;
         $display("FAIL load_writes: %0d writes missing, required 0", exp_q0.size());
      end
   endtask

   task automatic test_bad_checksum();
      sel = 0;
      do_start();
      n_checks++;
      if (if0.cpu_reset !== 1'b1 || if0.done !== 1'b0) begin
         n_errors++;
         $display("FAIL restart_from_run: cpu_reset=%b done=%b, required 1 0", if0.cpu_reset, if0.done);
      end
      send_frame(0, 16'd5, 16'hCF40);
      n_checks++;
      if ({if0.error, if0.done, if0.cpu_reset} !== 3'b101) begin
         n_errors++;
         $display("FAIL bad_chk: error/done/cpu_reset=%b, required 101",
                  {if0.error, if0.done, if0.cpu_reset});
      end
      n_checks++;
      if (exp_q0.size() != 0) begin
         n_errors++;
         $display("FAIL bad_chk_writes: %0d writes missing, required 0", exp_q0.size());
      end
   endtask

   task automatic test_empty();
      sel = 0;
      frame_words.delete();
      do_start();
      send_frame(0, 16'd0, 16'h0000);
      n_checks++;
      if ({if0.done, if0.cpu_reset, if0.error} !== 3'b100) begin
         n_errors++;
         $display("FAIL empty: done/cpu_reset/error=%b, required 100",
                  {if0.done, if0.cpu_reset, if0.error});
      end
   endtask

   task automatic test_start_collision();
      sel = 0;
      frame_words.delete();
      start    = 1'b1;
      rx_data  = 8'hFF;
      rx_valid = 1'b1;
      tick();
      start    = 1'b0;
      rx_valid = 1'b0;
      send_frame(0, 16'd0, 16'h0000);
      n_checks++;
      if (if0.done !== 1'b1 || if0.error !== 1'b0) begin
         n_errors++;
         $display("FAIL start_collision: done=%b error=%b, required 1 0", if0.done, if0.error);
      end
   endtask

   task automatic test_timeout();
      sel = 1;
      do_start();
      send_byte(8'h00);
      send_byte(8'h05);
      send_byte(8'h00);
      repeat (15) tick();
      n_checks++;
      if (if1.error !== 1'b0 || if1.busy !== 1'b1) begin
         n_errors++;
         $display("FAIL timeout_early: error=%b busy=%b after 15 idle cycles, required 0 1",
                  if1.error, if1.busy);
      end
      tick();
      n_checks++;
      if (if1.error !== 1'b1 || if1.busy !== 1'b0 || if1.cpu_reset !== 1'b1) begin
         n_errors++;
         $display("FAIL timeout: error=%b busy=%b cpu_reset=%b after 16 idle cycles, required 1 0 1",
                  if1.error, if1.busy, if1.cpu_reset);
      end
   endtask

   task automatic test_len_limit();
      logic [15:0] sum;
      sel = 2;
      do_start();
      send_byte(8'h00);
      send_byte(8'h11);
      n_checks++;
      if (if2.error !== 1'b1 || if2.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL len_over: error=%b busy=%b, required 1 0", if2.error, if2.busy);
      end
      frame_words.delete();
      sum = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         frame_words.push_back(16'($urandom));
         sum = sum + frame_words[i];
      end
      do_start();
      send_frame(2, 16'd16, sum);
      n_checks++;
      if (if2.done !== 1'b1 || if2.error !== 1'b0 || if2.cpu_reset !== 1'b0) begin
         n_errors++;
         $display("FAIL len_max: done=%b error=%b cpu_reset=%b, required 1 0 0",
                  if2.done, if2.error, if2.cpu_reset);
      end
      n_checks++;
      if (exp_q2.size() != 0) begin
         n_errors++;
         $display("FAIL len_max_writes: %0d writes missing, required 0", exp_q2.size());
      end
   endtask

   task automatic test_async_reset();
      sel = 0;
      do_start();
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'hAB);
      send_byte(8'hCD);
      n_checks++;
      if (if0.im_we !== 1'b1) begin
         n_errors++;
         $display("FAIL pre_reset_we: im_we=%b, required 1", if0.im_we);
      end
      #1 reset = 1'b0;
      #1;
      n_checks++;
      if ({if0.im_we, if0.cpu_reset, if0.busy} !== 3'b010 || if0.im_d !== 16'h0000) begin
         n_errors++;
         $display("FAIL async_reset: we/cpu_reset/busy=%b im_d=%h, required 010 0000",
                  {if0.im_we, if0.cpu_reset, if0.busy}, if0.im_d);
      end
      tick();
      reset = 1'b1;
      tick();
      send_byte(8'h00);
      n_checks++;
      if ({if0.busy, if0.done, if0.error, if0.cpu_reset} !== 4'b0001) begin
         n_errors++;
         $display("FAIL idle_after_reset: busy/done/error/cpu_reset=%b, required 0001",
                  {if0.busy, if0.done, if0.error, if0.cpu_reset});
      end
   endtask

   task automatic test_back_to_back();
      sel = 0;
      frame_words = '{16'h1234, 16'hFFFF, 16'h0001};
      do_start();
      send_frame(0, 16'd3, 16'h1234);
      n_checks++;
      if (if0.done !== 1'b1) begin
         n_errors++;
         $display("FAIL reload_first: done=%b, required 1", if0.done);
      end
      frame_words = '{16'hBEEF};
      do_start();
      n_checks++;
      if (if0.cpu_reset !== 1'b1) begin
         n_errors++;
         $display("FAIL reload_cpu_reset: cpu_reset=%b, required 1", if0.cpu_reset);
      end
      send_frame(0, 16'd1, 16'hBEEF);
      n_checks++;
      if (if0.done !== 1'b1 || if0.im_address !== 15'd0 || if0.im_d !== 16'hBEEF) begin
         n_errors++;
         $display("FAIL reload_second: done=%b addr=%0d d=%h, required 1 0 beef",
                  if0.done, if0.im_address, if0.im_d);
      end
      n_checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0 || exp_q2.size() != 0) begin
         n_errors++;
         $display("FAIL final_writes: %0d/%0d/%0d writes missing, required 0/0/0",
                  exp_q0.size(), exp_q1.size(), exp_q2.size());
      end
   endtask

   initial begin
      test_reset();
      test_load_ok();
      test_bad_checksum();
      test_empty();
      test_start_collision();
      test_timeout();
      test_len_limit();
      test_async_reset();
      test_back_to_back();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
